// File: rtl/baud_pkg.sv
// Shared types and helpers for the fractional UART baud generator.
package baud_pkg;

    localparam int DIV_INT_WIDTH_DEF  = 16;
    localparam int DIV_FRAC_WIDTH_DEF = 4;

    typedef enum logic [1:0] {
        OS_16   = 2'd0,
        OS_8    = 2'd1,
        OS_4    = 2'd2,
        OS_RSVD = 2'd3
    } os_sel_e;

    typedef struct packed {
        logic [DIV_INT_WIDTH_DEF-1:0]  div_int;
        logic [DIV_FRAC_WIDTH_DEF-1:0] div_frac;
        os_sel_e                       os_sel;
    } baud_cfg_t;

    // Reserved encoding falls back to 16x.
    function automatic logic [4:0] os_ratio(input os_sel_e sel);
        logic [4:0] ratio;
        case (sel)
            OS_8:    ratio = 5'd8;
            OS_4:    ratio = 5'd4;
            default: ratio = 5'd16;
        endcase
        return ratio;
    endfunction

endpackage

// File: rtl/baud_frac_div.sv
// Fractional period generator: oversample periods of N or N+1 cycles, averaging
// N + F/2^DIV_FRAC_WIDTH, driven by a carry out of the fractional accumulator.
module baud_frac_div #(
    parameter int DIV_INT_WIDTH  = 16,
    parameter int DIV_FRAC_WIDTH = 4
) (
    input  logic                      uart_clk,
    input  logic                      rst_n,
    input  logic                      clr,
    input  logic                      fresh,
    input  logic [DIV_INT_WIDTH-1:0]  div_int,
    input  logic [DIV_FRAC_WIDTH-1:0] div_frac,
    output logic                      period_end,
    output logic                      tick_os
);

    localparam int CW = DIV_INT_WIDTH + 1;

    logic [CW-1:0]             cnt;
    logic [DIV_FRAC_WIDTH-1:0] acc;
    logic                      ext;

    logic [DIV_FRAC_WIDTH-1:0] acc_cur;
    logic                      ext_cur;
    logic [DIV_FRAC_WIDTH:0]   sum;
    logic [CW-1:0]             cnt_inc;
    logic [CW-1:0]             period_len;

    // NOTE: every always_comb target is assigned on every path, so no latch is inferred.
    always_comb begin
        acc_cur    = fresh ? '0 : acc;
        ext_cur    = fresh ? 1'b0 : ext;
        sum        = {1'b0, acc_cur} + {1'b0, div_frac};
        cnt_inc    = cnt + CW'(1);
        period_len = {1'b0, div_int} + CW'(ext_cur);
        period_end = !clr && (cnt_inc == period_len);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge uart_clk) begin
        if (!rst_n || clr) begin
            cnt     <= '0;
            acc     <= '0;
            ext     <= 1'b0;
            tick_os <= 1'b0;
        end else if (period_end) begin
            cnt     <= '0;
            acc     <= sum[DIV_FRAC_WIDTH-1:0];
            ext     <= sum[DIV_FRAC_WIDTH];
            tick_os <= 1'b1;
        end else begin
            cnt     <= cnt_inc;
            acc     <= acc_cur;
            ext     <= ext_cur;
            tick_os <= 1'b0;
        end
    end

endmodule

// File: rtl/baud_gen_frac.sv
// Fractional UART baud generator with double-buffered config and oversample/bit/mid ticks.
// Optional macro BAUD_GEN_TICK_CNT_EN builds a 32-bit tick_bit counter on tick_cnt.
module baud_gen_frac
    import baud_pkg::*;
#(
    parameter int DIV_INT_WIDTH  = DIV_INT_WIDTH_DEF,
    parameter int DIV_FRAC_WIDTH = DIV_FRAC_WIDTH_DEF
) (
    input  logic                      uart_clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic                      cfg_load,
    input  logic [DIV_INT_WIDTH-1:0]  cfg_div_int,
    input  logic [DIV_FRAC_WIDTH-1:0] cfg_div_frac,
    input  logic [1:0]                cfg_os_sel,
    input  logic                      phase_rst,
    output logic                      tick_os,
    output logic                      tick_bit,
    output logic                      tick_mid,
    output logic                      cfg_pending,
    output logic                      cfg_err,
    output logic [31:0]               tick_cnt
);

    typedef struct packed {
        logic [DIV_INT_WIDTH-1:0]  div_int;
        logic [DIV_FRAC_WIDTH-1:0] div_frac;
        os_sel_e                   os_sel;
    } cfg_t;

    cfg_t       cfg_act, cfg_shd, cfg_in, cfg_new, cfg_eff;
    logic       act_idle, apply_now, clr, fresh;
    logic       period_end, bit_end, mid_end;
    logic [4:0] ratio;
    logic [3:0] os_cnt;
    logic [4:0] os_cnt_inc;

    always_comb begin
        cfg_in.div_int  = cfg_div_int;
        cfg_in.div_frac = cfg_div_frac;
        cfg_in.os_sel   = os_sel_e'(cfg_os_sel);

        // An active N of 0 (including the post-reset state) counts as idle, so loads apply at once.
        act_idle  = (cfg_act.div_int == '0);
        apply_now = (cfg_pending || cfg_load) && (tick_bit || phase_rst || !enable || act_idle);
        cfg_new   = cfg_load ? cfg_in : cfg_shd;
        cfg_eff   = apply_now ? cfg_new : cfg_act;
        clr       = !enable || phase_rst || act_idle || (cfg_eff.div_int == '0);
        fresh     = apply_now && tick_bit;

        ratio      = os_ratio(cfg_eff.os_sel);
        os_cnt_inc = {1'b0, os_cnt} + 5'd1;
        bit_end    = period_end && (os_cnt_inc == ratio);
        mid_end    = period_end && (os_cnt_inc == {1'b0, ratio[4:1]});
    end

    baud_frac_div #(
        .DIV_INT_WIDTH  (DIV_INT_WIDTH),
        .DIV_FRAC_WIDTH (DIV_FRAC_WIDTH)
    ) u_frac_div (
        .uart_clk   (uart_clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .fresh      (fresh),
        .div_int    (cfg_eff.div_int),
        .div_frac   (cfg_eff.div_frac),
        .period_end (period_end),
        .tick_os    (tick_os)
    );

    // cfg_err is registered at apply time so reset leaves it low despite the zeroed config.
    always_ff @(posedge uart_clk) begin
        if (!rst_n) begin
            cfg_act     <= '0;
            cfg_shd     <= '0;
            cfg_pending <= 1'b0;
            cfg_err     <= 1'b0;
            os_cnt      <= '0;
            tick_bit    <= 1'b0;
            tick_mid    <= 1'b0;
        end else begin
            if (cfg_load) begin
                cfg_shd <= cfg_in;
            end
            if (apply_now) begin
                cfg_act     <= cfg_new;
                cfg_err     <= (cfg_new.div_int == '0);
                cfg_pending <= 1'b0;
            end else if (cfg_load) begin
                cfg_pending <= 1'b1;
            end

            if (clr) begin
                os_cnt   <= '0;
                tick_bit <= 1'b0;
                tick_mid <= 1'b0;
            end else begin
                tick_bit <= bit_end;
                tick_mid <= mid_end;
                if (bit_end) begin
                    os_cnt <= '0;
                end else if (period_end) begin
                    os_cnt <= os_cnt_inc[3:0];
                end
            end
        end
    end

`ifdef BAUD_GEN_TICK_CNT_EN
    always_ff @(posedge uart_clk) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else if (bit_end) begin
            tick_cnt <= tick_cnt + 32'd1;
        end
    end
`else
    assign tick_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_baud_gen_frac.sv
// Directed self-checking bench for baud_gen_frac (default 16/4 widths).
module tb_baud_gen_frac;

    logic        uart_clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        cfg_load;
    logic [15:0] cfg_div_int;
    logic [3:0]  cfg_div_frac;
    logic [1:0]  cfg_os_sel;
    logic        phase_rst;
    logic        tick_os, tick_bit, tick_mid, cfg_pending, cfg_err;
    logic [31:0] tick_cnt;

    int n_checks = 0;
    int n_fails  = 0;

`ifdef BAUD_GEN_TICK_CNT_EN
    localparam bit TC_EN = 1'b1;
`else
    localparam bit TC_EN = 1'b0;
`endif

    baud_gen_frac dut (
        .uart_clk     (uart_clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .cfg_load     (cfg_load),
        .cfg_div_int  (cfg_div_int),
        .cfg_div_frac (cfg_div_frac),
        .cfg_os_sel   (cfg_os_sel),
        .phase_rst    (phase_rst),
        .tick_os      (tick_os),
        .tick_bit     (tick_bit),
        .tick_mid     (tick_mid),
        .cfg_pending  (cfg_pending),
        .cfg_err      (cfg_err),
        .tick_cnt     (tick_cnt)
    );

    always #5 uart_clk = ~uart_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Count falling edges until the selected tick is seen (0=os, 1=bit, 2=mid); -1 if bound expires.
    task automatic wait_tick(input int sel, input int bound, output int n);
        bit seen;
        seen = 1'b0;
        n = -1;
        for (int i = 1; i <= bound && !seen; i++) begin
            @(negedge uart_clk);
            if ((sel == 0 && tick_os) || (sel == 1 && tick_bit) || (sel == 2 && tick_mid)) begin
                n = i;
                seen = 1'b1;
            end
        end
    endtask

    // Reconfigure through a disabled cycle, then enable; the next rising edge is edge 1.
    task automatic restart_cfg(input int n, input int f, input int os);
        enable       = 1'b0;
        cfg_load     = 1'b1;
        cfg_div_int  = 16'(n);
        cfg_div_frac = 4'(f);
        cfg_os_sel   = 2'(os);
        @(negedge uart_clk);
        cfg_load = 1'b0;
        enable   = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int total;

        rst_n = 1'b0; enable = 1'b0; cfg_load = 1'b0; phase_rst = 1'b0;
        cfg_div_int = '0; cfg_div_frac = '0; cfg_os_sel = '0;
        repeat (3) @(negedge uart_clk);
        check("rst_tick_os", 32'(tick_os), 0);
        check("rst_tick_bit", 32'(tick_bit), 0);
        check("rst_tick_mid", 32'(tick_mid), 0);
        check("rst_pending", 32'(cfg_pending), 0);
        check("rst_err", 32'(cfg_err), 0);
        check("rst_tick_cnt", tick_cnt, 0);
        rst_n = 1'b1;
        @(negedge uart_clk);

        // N=4, F=0, 16x
        restart_cfg(4, 0, 0);
        check("t1_pending", 32'(cfg_pending), 0);
        wait_tick(0, 50, n);  check("t1_os_first", n, 4);
        wait_tick(0, 50, n);  check("t1_os_second", n, 4);
        wait_tick(2, 100, n); check("t1_mid_first", n, 24);
        wait_tick(1, 100, n); check("t1_bit_first", n, 32);
        check("t1_os_with_bit", 32'(tick_os), 1);
        wait_tick(2, 100, n); check("t1_mid_after_bit", n, 32);
        wait_tick(1, 100, n); check("t1_bit_period", n, 32);

        // N=4, F=8: periods 4,4,5,4,5 then a 16-period window of 72 cycles
        restart_cfg(4, 8, 0);
        wait_tick(0, 50, n); check("t2_p1", n, 4);
        wait_tick(0, 50, n); check("t2_p2", n, 4);
        wait_tick(0, 50, n); check("t2_p3", n, 5);
        wait_tick(0, 50, n); check("t2_p4", n, 4);
        wait_tick(0, 50, n); check("t2_p5", n, 5);
        total = 0;
        for (int i = 0; i < 16; i++) begin
            wait_tick(0, 50, n);
            total += n;
        end
        check("t2_16_periods", total, 72);

        // Mid-bit load of N=2 waits for the bit boundary
        cfg_load = 1'b1; cfg_div_int = 16'd2; cfg_div_frac = 4'd0; cfg_os_sel = 2'd0;
        @(negedge uart_clk);
        cfg_load = 1'b0;
        check("t3_pending_set", 32'(cfg_pending), 1);
        wait_tick(1, 200, n); check("t3_bit_seen", 32'(n > 0), 1);
        wait_tick(0, 20, n);  check("t3_os_new_period", n, 2);
        check("t3_pending_clr", 32'(cfg_pending), 0);
        wait_tick(1, 100, n); check("t3_bit_new", n, 30);

        // Load coincident with tick_bit: N=3, 8x applied directly
        cfg_load = 1'b1; cfg_div_int = 16'd3; cfg_os_sel = 2'd1;
        @(negedge uart_clk);
        cfg_load = 1'b0;
        check("t3_coinc_pending", 32'(cfg_pending), 0);
        wait_tick(0, 20, n);  check("t3_coinc_os1", n, 2);
        wait_tick(0, 20, n);  check("t3_coinc_os2", n, 3);
        wait_tick(1, 100, n); check("t3_coinc_bit", n, 18);

        // phase_rst on the edge a tick would have fired, N=10
        restart_cfg(10, 0, 0);
        wait_tick(0, 50, n); check("t4_os_first", n, 10);
        repeat (9) @(negedge uart_clk);
        phase_rst = 1'b1;
        @(negedge uart_clk);
        phase_rst = 1'b0;
        check("t4_no_tick", 32'(tick_os), 0);
        wait_tick(0, 50, n);  check("t4_os_after_ph", n, 10);
        wait_tick(2, 200, n); check("t4_mid_after_ph", n, 70);

        // N=0 is an error and idle; a valid load then applies immediately
        restart_cfg(0, 0, 0);
        check("t5_err_set", 32'(cfg_err), 1);
        wait_tick(0, 40, n); check("t5_no_tick", n, -1);
        cfg_load = 1'b1; cfg_div_int = 16'd3; cfg_div_frac = 4'd0; cfg_os_sel = 2'd0;
        @(negedge uart_clk);
        cfg_load = 1'b0;
        check("t5_err_clr", 32'(cfg_err), 0);
        check("t5_pending", 32'(cfg_pending), 0);
        wait_tick(0, 20, n); check("t5_os1", n, 3);
        wait_tick(0, 20, n); check("t5_os2", n, 3);

        // Reset on the cycle before a tick is due
        repeat (2) @(negedge uart_clk);
        rst_n = 1'b0;
        @(negedge uart_clk);
        check("t5_rst_os", 32'(tick_os), 0);
        check("t5_rst_err", 32'(cfg_err), 0);
        check("t5_rst_pending", 32'(cfg_pending), 0);
        rst_n = 1'b1;
        @(negedge uart_clk);

        // N=1, F=0, 4x: continuous tick_os, tick_bit every 4 cycles
        restart_cfg(1, 0, 2);
        wait_tick(1, 20, n); check("t6_bit_first", n, 4);
        check("t6_cnt1", tick_cnt, TC_EN ? 32'd1 : 32'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge uart_clk);
            check("t6_os_cont", 32'(tick_os), 1);
        end
        check("t6_cnt3", tick_cnt, TC_EN ? 32'd3 : 32'd0);
        enable = 1'b0;
        repeat (5) @(negedge uart_clk);
        check("t6_cnt_hold", tick_cnt, TC_EN ? 32'd3 : 32'd0);
        check("t6_dis_os", 32'(tick_os), 0);
        enable = 1'b1;
        wait_tick(0, 10, n); check("t6_resume", n, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
